// File: rtl/mux21_arbiter.sv
// Two-requester round-robin arbiter steering a 2:1 data mux into a one-entry
// registered output stage. Ownership is bounded by in_last or MAX_BURST beats.
module mux21_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [1:0]       in_last,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       prio;
  logic [7:0] count;

  logic       own;
  logic       accept;
  logic       xfer;
  logic [8:0] count_inc;
  logic       beat_last;
  logic       own_end;
  logic       arbitrate;
  logic       prio_eff;

  assign busy = (state != IDLE);

  // Handshakes: a beat moves in when req[i] && gnt[i]; a beat moves out when
  // out_valid && out_ready. gnt depends only on registered state and out_ready.
  always_comb begin
    own       = (state == OWN1);
    accept    = !out_valid || out_ready;
    gnt       = 2'b00;
    if (state == OWN0) gnt[0] = accept;
    if (state == OWN1) gnt[1] = accept;
    xfer      = |(req & gnt);
    count_inc = {1'b0, count} + 9'd1;
    beat_last = in_last[own] || (count_inc == 9'(MAX_BURST));
    own_end   = busy && ((xfer && beat_last) || !req[own]);
    arbitrate = !busy || own_end;
    prio_eff  = own_end ? ~own : prio;

    state_next = state;
    if (arbitrate) begin
      unique case (req)
        2'b01:   state_next = OWN0;
        2'b10:   state_next = OWN1;
        2'b11:   state_next = prio_eff ? OWN1 : OWN0;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      sel       <= 1'b0;
      count     <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_eff;

      // A fresh ownership restarts the beat count even when re-granted.
      if (arbitrate && (state_next != IDLE)) begin
        sel   <= (state_next == OWN1);
        count <= 8'd0;
      end else if (xfer) begin
        count <= count_inc[7:0];
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel ? in_data1 : in_data0;
        out_last  <= beat_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
